// File: rtl/idec_pkg.sv
// Shared types and defaults for the pipelined instruction decoder.
//   - idec_state_t  : word-assembly state (expecting word 1 / word 2)
//   - idec_fields_t : opcode and register selects of an instruction word,
//                     MSB first (op, dest, s1, s2)
//   - is_two_word() : opcode MSB set and opcode not illegal
package idec_pkg;

  localparam int IDEC_OP_W       = 4;
  localparam int IDEC_REG_ADDR_W = 4;
  localparam int IDEC_WORD_W     = IDEC_OP_W + 3 * IDEC_REG_ADDR_W;

  typedef enum logic {
    IDEC_W1 = 1'b0,
    IDEC_W2 = 1'b1
  } idec_state_t;

  typedef struct packed {
    logic [IDEC_OP_W-1:0]       op;
    logic [IDEC_REG_ADDR_W-1:0] dest;
    logic [IDEC_REG_ADDR_W-1:0] s1;
    logic [IDEC_REG_ADDR_W-1:0] s2;
  } idec_fields_t;

  // Illegal opcodes are always single-word, even with the MSB set.
  function automatic logic is_two_word(
    input logic [IDEC_OP_W-1:0]      op,
    input logic [2**IDEC_OP_W-1:0]   illegal_mask
  );
    return op[IDEC_OP_W-1] && !illegal_mask[op];
  endfunction

endpackage

// File: rtl/idec_field_decode.sv
// Combinational split of one instruction word into its fields.
// Ports:
//   i_word       in   instruction word
//   o_fields     out  op/dest/s1/s2
//   o_illegal    out  opcode flagged in ILLEGAL_MASK
//   o_two_word   out  word is the first half of an immediate-carrying instr
module idec_field_decode
  import idec_pkg::*;
#(
  parameter int                       OP_W         = IDEC_OP_W,
  parameter int                       WORD_W       = IDEC_WORD_W,
  parameter logic [(1<<OP_W)-1:0]     ILLEGAL_MASK = 16'h8080
) (
  input  logic [WORD_W-1:0] i_word,
  output idec_fields_t      o_fields,
  output logic              o_illegal,
  output logic              o_two_word
);

  assign o_fields   = i_word;
  assign o_illegal  = ILLEGAL_MASK[o_fields.op];
  assign o_two_word = is_two_word(o_fields.op, ILLEGAL_MASK);

endmodule

// File: rtl/instruction_decoder_pipe.sv
// Pipelined instruction decoder: assembles one- or two-word instructions from
// a valid/ready word stream and presents the decode in a registered output
// stage with its own valid/ready handshake.
// Optional feature: define IDEC_ERR_CNT_EN to add o_err_cnt, a saturating
// count of transferred illegal-opcode results (not cleared by flush).
// Ports:
//   i_clk, i_rst_n (async, active low), i_flush (sync, drops state + output)
//   i_ir/i_valid/o_ready         : word input handshake
//   o_valid/i_ready              : decoded output handshake
//   o_op/o_dest/o_s1/o_s2/o_imm  : decoded fields, o_imm=0 for one-word
//   o_two_word, o_err            : immediate present / illegal opcode
//   o_err_cnt                    : (IDEC_ERR_CNT_EN only) error count
module instruction_decoder_pipe
  import idec_pkg::*;
#(
  parameter int                       WORD_W       = 16,
  parameter int                       OP_W         = 4,
  parameter int                       REG_ADDR_W   = 4,
  parameter logic [(1<<OP_W)-1:0]     ILLEGAL_MASK = 16'h8080
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic [WORD_W-1:0]     i_ir,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [OP_W-1:0]       o_op,
  output logic [REG_ADDR_W-1:0] o_dest,
  output logic [REG_ADDR_W-1:0] o_s1,
  output logic [REG_ADDR_W-1:0] o_s2,
  output logic [WORD_W-1:0]     o_imm,
  output logic                  o_two_word,
  output logic                  o_err
`ifdef IDEC_ERR_CNT_EN
  ,
  output logic [7:0]            o_err_cnt
`endif
);

  // The field struct is sized by the package defaults.
  generate
    if (WORD_W != OP_W + 3 * REG_ADDR_W || OP_W != IDEC_OP_W ||
        REG_ADDR_W != IDEC_REG_ADDR_W) begin : g_bad_params
      $error("instruction_decoder_pipe: inconsistent field widths");
    end
  endgenerate

  idec_state_t  r_state;
  idec_fields_t r_w1;       // latched word 1 of a two-word instruction
  idec_fields_t w_cur;
  logic         w_illegal;
  logic         w_two;
  logic         w_accept;
  logic         w_complete;
  logic         w_xfer;

  idec_field_decode #(
    .OP_W         (OP_W),
    .WORD_W       (WORD_W),
    .ILLEGAL_MASK (ILLEGAL_MASK)
  ) u_dec (
    .i_word     (i_ir),
    .o_fields   (w_cur),
    .o_illegal  (w_illegal),
    .o_two_word (w_two)
  );

  assign o_ready    = !o_valid || i_ready;
  assign w_accept   = i_valid && o_ready;
  assign w_xfer     = o_valid && i_ready;
  assign w_complete = w_accept && (r_state == IDEC_W2 || !w_two);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDEC_W1;
      r_w1       <= '0;
      o_valid    <= 1'b0;
      o_op       <= '0;
      o_dest     <= '0;
      o_s1       <= '0;
      o_s2       <= '0;
      o_imm      <= '0;
      o_two_word <= 1'b0;
      o_err      <= 1'b0;
    end else if (i_flush) begin
      // Flush beats any accept/completion this cycle; data regs just hold.
      r_state <= IDEC_W1;
      r_w1    <= '0;
      o_valid <= 1'b0;
    end else begin
      if (w_complete) begin
        o_valid <= 1'b1;
        if (r_state == IDEC_W2) begin
          o_op       <= r_w1.op;
          o_dest     <= r_w1.dest;
          o_s1       <= r_w1.s1;
          o_s2       <= r_w1.s2;
          o_imm      <= i_ir;
          o_two_word <= 1'b1;
          o_err      <= 1'b0;
        end else if (w_illegal) begin
          o_op       <= w_cur.op;
          o_dest     <= '0;
          o_s1       <= '0;
          o_s2       <= '0;
          o_imm      <= '0;
          o_two_word <= 1'b0;
          o_err      <= 1'b1;
        end else begin
          o_op       <= w_cur.op;
          o_dest     <= w_cur.dest;
          o_s1       <= w_cur.s1;
          o_s2       <= w_cur.s2;
          o_imm      <= '0;
          o_two_word <= 1'b0;
          o_err      <= 1'b0;
        end
      end else if (w_xfer) begin
        o_valid <= 1'b0;
      end

      if (w_accept) begin
        if (r_state == IDEC_W2) begin
          r_state <= IDEC_W1;
        end else if (w_two) begin
          r_state <= IDEC_W2;
          r_w1    <= w_cur;
        end
      end
    end
  end

`ifdef IDEC_ERR_CNT_EN
  // Counts on transfer, so a flushed-away result was still seen downstream
  // if it transferred in the flush cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err_cnt <= 8'h00;
    end else if (w_xfer && o_err && o_err_cnt != 8'hFF) begin
      o_err_cnt <= o_err_cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_decoder_pipe.sv
module tb_instruction_decoder_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic [15:0] i_ir = '0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [3:0]  o_op, o_dest, o_s1, o_s2;
  logic [15:0] o_imm;
  logic        o_two_word, o_err;
`ifdef IDEC_ERR_CNT_EN
  logic [7:0]  o_err_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  instruction_decoder_pipe dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (i_flush),
    .i_ir       (i_ir),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_op       (o_op),
    .o_dest     (o_dest),
    .o_s1       (o_s1),
    .o_s2       (o_s2),
    .o_imm      (o_imm),
    .o_two_word (o_two_word),
    .o_err      (o_err)
`ifdef IDEC_ERR_CNT_EN
    ,
    .o_err_cnt  (o_err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Present one word for one cycle (drive at negedge, sample at next negedge).
  task automatic put(input logic [15:0] w);
    i_valid = 1'b1;
    i_ir    = w;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic chk_dec(input string tag, input logic [3:0] op, input logic [3:0] d,
                         input logic [3:0] a, input logic [3:0] b, input logic [15:0] imm,
                         input logic two, input logic err);
    chk({tag, ".valid"}, o_valid, 1'b1);
    chk({tag, ".op"},    o_op,    op);
    chk({tag, ".dest"},  o_dest,  d);
    chk({tag, ".s1"},    o_s1,    a);
    chk({tag, ".s2"},    o_s2,    b);
    chk({tag, ".imm"},   o_imm,   imm);
    chk({tag, ".two"},   o_two_word, two);
    chk({tag, ".err"},   o_err,   err);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge i_clk);
    chk("rst.valid", o_valid, 1'b0);
    chk("rst.op",    o_op,    4'h0);
    chk("rst.imm",   o_imm,   16'h0);
    chk("rst.err",   o_err,   1'b0);
    chk("rst.ready", o_ready, 1'b1);
`ifdef IDEC_ERR_CNT_EN
    chk("rst.errcnt", o_err_cnt, 8'h00);
`endif
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // One-word, one cycle latency
    put(16'h1234);
    chk_dec("one", 4'h1, 4'h2, 4'h3, 4'h4, 16'h0, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("one.drain", o_valid, 1'b0);

    // Two-word
    put(16'h8A50);
    chk("two.wait", o_valid, 1'b0);
    put(16'hBEEF);
    chk_dec("two", 4'h8, 4'hA, 4'h5, 4'h0, 16'hBEEF, 1'b1, 1'b0);

    // Illegal opcodes; F000 must not wait for a second word, back-to-back
    put(16'h7123);
    chk_dec("ill7", 4'h7, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 1'b1);
    put(16'hF000);
    chk_dec("illF", 4'hF, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0, 1'b1);
    put(16'h1234);
    chk_dec("afterF", 4'h1, 4'h2, 4'h3, 4'h4, 16'h0, 1'b0, 1'b0);
    @(negedge i_clk);

    // Backpressure
    i_ready = 1'b0;
    put(16'h1234);
    i_valid = 1'b1;
    i_ir    = 16'h2345;
    #1 chk("bp.ready0", o_ready, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("bp.valid", o_valid, 1'b1);
      chk("bp.op",    o_op,    4'h1);
      chk("bp.dest",  o_dest,  4'h2);
      chk("bp.ready", o_ready, 1'b0);
    end
    i_ready = 1'b1;
    #1 chk("bp.ready1", o_ready, 1'b1);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk_dec("bp.next", 4'h2, 4'h3, 4'h4, 4'h5, 16'h0, 1'b0, 1'b0);
    @(negedge i_clk);
    chk("bp.drain", o_valid, 1'b0);

    // Flush while in W2: following word decodes as word 1
    put(16'h8A50);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("fl.w2.valid", o_valid, 1'b0);
    put(16'h1234);
    chk_dec("fl.after", 4'h1, 4'h2, 4'h3, 4'h4, 16'h0, 1'b0, 1'b0);
    // Flush coinciding with a completing one-word
    i_flush = 1'b1;
    put(16'h5678);
    i_flush = 1'b0;
    chk("fl.one.valid", o_valid, 1'b0);
    // Flush coinciding with a completing second word
    put(16'h8A50);
    i_flush = 1'b1;
    put(16'hBEEF);
    i_flush = 1'b0;
    chk("fl.two.valid", o_valid, 1'b0);
    put(16'h1234);
    chk_dec("fl.two.after", 4'h1, 4'h2, 4'h3, 4'h4, 16'h0, 1'b0, 1'b0);
    @(negedge i_clk);

    // Async reset mid-W2
    put(16'h8A50);
    chk("rw2.wait", o_valid, 1'b0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rw2.valid", o_valid, 1'b0);
    chk("rw2.op",    o_op,    4'h0);
    chk("rw2.dest",  o_dest,  4'h0);
`ifdef IDEC_ERR_CNT_EN
    chk("rw2.errcnt", o_err_cnt, 8'h00);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    put(16'hBEEF);
    chk("rw2.beef.wait", o_valid, 1'b0);
    put(16'h0001);
    chk_dec("rw2.beef", 4'hB, 4'hE, 4'hE, 4'hF, 16'h0001, 1'b1, 1'b0);
    @(negedge i_clk);

`ifdef IDEC_ERR_CNT_EN
    put(16'h7123);
    @(negedge i_clk);
    chk("cnt.one", o_err_cnt, 8'h01);
    for (int k = 0; k < 300; k++) put(16'h7123);
    @(negedge i_clk);
    chk("cnt.sat", o_err_cnt, 8'hFF);
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    chk("cnt.flush", o_err_cnt, 8'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
